audio_tone_gen: RTL and testbench

Note player for the audio path. It accepts one note at a time over a valid/ready handshake and generates a square wave at the requested half-period for the requested number of millisecond ticks. It gates the wave with a 5-bit PWM volume compare against the `pwm_cnt` ramp, which is produced by the upstream 5-bit free-running counter. Its `pwm_en` output drives that counter's enable, so the ramp runs only while a note is active.

---
 rtl/audio_tone_gen.sv | 165 ++++++++++++++++
 tb/tb_audio_tone_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// audio_tone_gen: handshaked note player producing a PWM-gated square wave.
// Rev 1.0
// ----------------------------------------------------------------------------
module audio_tone_gen #(
  parameter int HP_W      = 18,
  parameter int DUR_W     = 16,
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       pwm_cnt,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [HP_W-1:0]  note_half_period,
  input  logic [DUR_W-1:0] note_duration,
  input  logic [4:0]       note_volume,
  output logic             pwm_en,
  output logic             busy,
  output logic             done,
  output logic             audio_out
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [HP_W-1:0]   r_hp;
  logic [HP_W-1:0]   r_hp_cnt;
  logic [DUR_W-1:0]  r_remain;
  logic [4:0]        r_vol;
  logic [TICK_W-1:0] r_tick;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_sq;

  logic w_accept;
  logic w_tick_wrap;
  logic w_hp_wrap;
  logic w_ready_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_audio_nxt;

  // note_ready is only ever high in IDLE, so it doubles as the state qualifier
  assign w_accept    = note_valid & note_ready;
  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_hp_wrap   = (r_hp != '0) && (r_hp_cnt == r_hp - HP_W'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (note_duration != '0)) begin
          w_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_tick_wrap && (r_remain == DUR_W'(1))) begin
          w_next = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (w_tick_wrap && (r_gap_cnt == GAP_LAST)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_next == S_IDLE);
    w_busy_nxt  = (w_next != S_IDLE);
    w_done_nxt  = ((r_state != S_IDLE) && (w_next == S_IDLE)) ||
                  (w_accept && (note_duration == '0));
    w_audio_nxt = (r_state == S_PLAY) && r_sq && (pwm_cnt < r_vol);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      note_ready <= 1'b0;
      busy       <= 1'b0;
      pwm_en     <= 1'b0;
      done       <= 1'b0;
      audio_out  <= 1'b0;
    end else begin
      note_ready <= w_ready_nxt;
      busy       <= w_busy_nxt;
      pwm_en     <= w_busy_nxt;
      done       <= w_done_nxt;
      audio_out  <= w_audio_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_hp      <= '0;
      r_hp_cnt  <= '0;
      r_remain  <= '0;
      r_vol     <= '0;
      r_tick    <= '0;
      r_gap_cnt <= '0;
      r_sq      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hp      <= note_half_period;
            r_remain  <= note_duration;
            r_vol     <= note_volume;
            r_hp_cnt  <= '0;
            r_tick    <= '0;
            r_gap_cnt <= '0;
            r_sq      <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_hp_wrap) begin
            r_hp_cnt <= '0;
            r_sq     <= ~r_sq;
          end else if (r_hp != '0) begin
            r_hp_cnt <= r_hp_cnt + HP_W'(1);
          end
          r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
          if (w_tick_wrap && (r_remain != '0)) begin
            r_remain <= r_remain - DUR_W'(1);
          end
          // leaving PLAY overrides any coincident toggle
          if (w_next != S_PLAY) begin
            r_sq <= 1'b0;
          end
        end
        S_GAP: begin
          r_sq   <= 1'b0;
          r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
          if (w_tick_wrap) begin
            r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_sq <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_gen.sv
`default_nettype none
// tb_audio_tone_gen: scoreboard bench; dut0 has no gap, dut1 a one-tick gap, TICK_DIV = 10.
module tb_audio_tone_gen;

  localparam int TD  = 10;
  localparam int HPW = 18;
  localparam int DW  = 16;

  typedef struct {
    int g;
    int n;
    int done_c;
    int busy;
    int acnt;
    int asum;
  } exp_t;

  logic           clk = 1'b0;
  logic           clr;
  logic [4:0]     pwm_cnt;
  logic [1:0]     valid;
  logic [HPW-1:0] n_hp;
  logic [DW-1:0]  n_dur;
  logic [4:0]     n_vol;
  logic [1:0]     ready_o, pen_o, busy_o, done_o, audio_o;

  int   cyc;
  int   mode;
  int   checks;
  int   failures;
  int   rtab [4096];
  int   free_c [2];
  exp_t sbq [$];
  int   m_act [2];
  int   m_start [2];
  int   m_busy [2];
  int   m_pen [2];
  int   m_acnt [2];
  int   m_asum [2];

  audio_tone_gen #(.HP_W(HPW), .DUR_W(DW), .TICK_DIV(TD), .GAP_TICKS(0)) dut0 (
    .clk(clk), .clr(clr), .pwm_cnt(pwm_cnt), .note_valid(valid[0]), .note_ready(ready_o[0]),
    .note_half_period(n_hp), .note_duration(n_dur), .note_volume(n_vol),
    .pwm_en(pen_o[0]), .busy(busy_o[0]), .done(done_o[0]), .audio_out(audio_o[0]));

  audio_tone_gen #(.HP_W(HPW), .DUR_W(DW), .TICK_DIV(TD), .GAP_TICKS(1)) dut1 (
    .clk(clk), .clr(clr), .pwm_cnt(pwm_cnt), .note_valid(valid[1]), .note_ready(ready_o[1]),
    .note_half_period(n_hp), .note_duration(n_dur), .note_volume(n_vol),
    .pwm_en(pen_o[1]), .busy(busy_o[1]), .done(done_o[1]), .audio_out(audio_o[1]));

  always #5 clk = ~clk;

  function automatic int pwm_of(input int c);
    if (mode == 0) return 0;
    if (mode == 1) return c % 32;
    return rtab[c % 4096];
  endfunction

  initial begin
    cyc     = 0;
    pwm_cnt = 5'd0;
    forever begin
      @(posedge clk);
      cyc++;
      #1 pwm_cnt = 5'(pwm_of(cyc));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: square high in odd half-periods of the note, gated by pwm < vol, one cycle late.
  function automatic exp_t model(input int g, input int n, input int hp, input int dur, input int vol);
    exp_t e;
    bit   hi;
    e.g    = g;
    e.n    = n;
    e.acnt = 0;
    e.asum = 0;
    if (dur == 0) begin
      e.done_c = n + 1;
      e.busy   = 0;
    end else begin
      e.done_c = n + 1 + (dur + g) * TD;
      e.busy   = (dur + g) * TD;
    end
    for (int k = 0; k < dur * TD; k++) begin
      hi = (hp != 0) && (((k / hp) % 2) == 1) && (pwm_of(n + 1 + k) < vol);
      if (hi) begin
        e.acnt++;
        e.asum += k + 2;
      end
    end
    return e;
  endfunction

  task automatic sb_pop(input int g);
    int   idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].g == g) begin
        idx = i;
        break;
      end
    end
    chk($sformatf("done_expected%0d", g), (idx >= 0 && m_act[g] != 0) ? 1 : 0, 1);
    if (idx >= 0 && m_act[g] != 0) begin
      e = sbq[idx];
      sbq.delete(idx);
      chk($sformatf("done_cycle%0d", g), cyc, e.done_c);
      chk($sformatf("busy_cycles%0d", g), m_busy[g], e.busy);
      chk($sformatf("pwm_en_cycles%0d", g), m_pen[g], e.busy);
      chk($sformatf("audio_count%0d", g), m_acnt[g], e.acnt);
      chk($sformatf("audio_pos_sum%0d", g), m_asum[g], e.asum);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clr) begin
        m_act[g] = 0;
      end else begin
        if (m_act[g] != 0) begin
          if (busy_o[g])  m_busy[g]++;
          if (pen_o[g])   m_pen[g]++;
          if (audio_o[g]) begin
            m_acnt[g]++;
            m_asum[g] += cyc - m_start[g];
          end
        end else begin
          chk($sformatf("idle_quiet%0d", g), int'({busy_o[g], pen_o[g], audio_o[g]}), 0);
        end
        if (done_o[g]) begin
          sb_pop(g);
          m_act[g] = 0;
        end
        if (valid[g] && ready_o[g]) begin
          m_act[g]   = 1;
          m_start[g] = cyc;
          m_busy[g]  = 0;
          m_pen[g]   = 0;
          m_acnt[g]  = 0;
          m_asum[g]  = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input int hp, input int dur, input int vol, input bit keep);
    int   start;
    int   waited;
    int   n;
    exp_t e;
    n_hp     = HPW'(hp);
    n_dur    = DW'(dur);
    n_vol    = 5'(vol);
    valid[g] = 1'b1;
    start    = cyc;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (ready_o[g]) break;
      waited++;
      if (waited > 1000) break;
    end
    if (!ready_o[g]) begin
      chk($sformatf("accept_timeout%0d", g), waited, 0);
      valid[g] = 1'b0;
      step();
      return;
    end
    n = cyc;
    chk($sformatf("accept_cycle%0d", g), n, (start > free_c[g]) ? start : free_c[g]);
    e = model(g, n, hp, dur, vol);
    sbq.push_back(e);
    free_c[g] = e.done_c;
    step();
    if (!keep) valid[g] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    chk("drain_pending", sbq.size(), 0);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mode     = 0;
    clr      = 1'b1;
    valid    = 2'b11;
    n_hp     = '0;
    n_dur    = '0;
    n_vol    = '0;
    for (int i = 0; i < 4096; i++) rtab[i] = int'($urandom_range(0, 31));
    for (int g = 0; g < 2; g++) begin
      free_c[g] = 0;
      m_act[g]  = 0;
      m_start[g] = 0;
      m_busy[g] = 0;
      m_pen[g]  = 0;
      m_acnt[g] = 0;
      m_asum[g] = 0;
    end

    // Reset held two cycles with note_valid high
    step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_ready%0d", g), int'(ready_o[g]), 0);
      chk($sformatf("rst_busy%0d", g), int'(busy_o[g]), 0);
      chk($sformatf("rst_pwm_en%0d", g), int'(pen_o[g]), 0);
      chk($sformatf("rst_done%0d", g), int'(done_o[g]), 0);
      chk($sformatf("rst_audio%0d", g), int'(audio_o[g]), 0);
    end
    step();
    clr   = 1'b0;
    valid = 2'b00;
    step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("post_rst_ready%0d", g), int'(ready_o[g]), 1);
      chk($sformatf("post_rst_busy%0d", g), int'(busy_o[g]), 0);
    end
    step();

    // Directed notes on the no-gap instance
    mode = 0;
    send(0, 3, 2, 31, 1'b0); drain();
    send(0, 3, 2, 0, 1'b0);  drain();
    mode = 1;
    send(0, 3, 2, 16, 1'b0); drain();
    mode = 0;
    send(0, 5, 0, 31, 1'b0); drain();
    send(0, 0, 3, 31, 1'b0); drain();

    // Back-to-back with note_valid held through PLAY on the gap instance
    send(1, 3, 2, 31, 1'b1);
    send(1, 2, 1, 20, 1'b0);
    drain();

    // Randomized notes on both instances with random PWM ramp values
    mode = 2;
    repeat (24) begin
      int g;
      g = int'($urandom_range(0, 1));
      send(g, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
    drain();

    // clr in the middle of PLAY
    mode = 0;
    send(0, 2, 3, 31, 1'b0);
    repeat (12) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    sbq.delete();
    free_c[0] = 0;
    free_c[1] = 0;
    @(negedge clk);
    chk("clr_busy", int'(busy_o[0]), 0);
    chk("clr_audio", int'(audio_o[0]), 0);
    chk("clr_done", int'(done_o[0]), 0);
    repeat (40) step();
    send(0, 3, 1, 31, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
